// File: rtl/calci_core.sv
// Calculator arithmetic engine: single-cycle add/sub/mul, 8-step restoring divide with Stall.
// Optional divider built only when CALCI_DIV_EN is defined; otherwise ctrl=11 returns zero.
module calci_core #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Valid,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [1:0]          ctrl,
    output logic                Stall,
    output logic [2*DATA_W-1:0] C,
    output logic                Done
);
    localparam int RES_W = 2 * DATA_W;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [RES_W-1:0]  r_c;
    logic              r_done;
    logic              w_accept;
    logic [DATA_W:0]   w_sum;
    logic [RES_W-1:0]  w_single;

    assign w_sum = {1'b0, A} + {1'b0, B};

    always_comb begin
        w_single = '0;
        case (ctrl)
            OP_ADD: w_single = {{(DATA_W-1){1'b0}}, w_sum};
            OP_SUB: w_single = {{DATA_W{1'b0}}, A} - {{DATA_W{1'b0}}, B};
            OP_MUL: w_single = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
            default: begin
`ifdef CALCI_DIV_EN
                // Only the divide-by-zero case resolves here; real divides run in S_DIV.
                w_single = {A, {DATA_W{1'b1}}};
`else
                w_single = '0;
`endif
            end
        endcase
    end

`ifdef CALCI_DIV_EN
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_stall;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_dvd;
    logic [DATA_W-1:0]  r_dvs;
    logic [DATA_W-1:0]  r_rem;
    logic               w_div_start;
    logic               w_last;
    logic [DATA_W:0]    w_shift;
    logic [DATA_W:0]    w_diff;
    logic               w_ge;
    logic [DATA_W-1:0]  w_rem_next;
    logic [DATA_W-1:0]  w_quo_next;

    assign w_accept = Valid && !r_stall;

    // r_dvd starts as the dividend and fills with quotient bits from the LSB as it shifts.
    assign w_shift    = {r_rem, r_dvd[DATA_W-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_quo_next = {r_dvd[DATA_W-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_div_start  = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (ctrl == OP_DIV) && (B != '0)) begin
                    w_div_start  = 1'b1;
                    w_next_state = S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c     <= '0;
            r_done  <= 1'b0;
            r_stall <= 1'b0;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_div_start) begin
                r_dvd   <= A;
                r_dvs   <= B;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_stall <= 1'b1;
            end else if (r_state == S_DIV) begin
                r_rem <= w_rem_next;
                r_dvd <= w_quo_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_c     <= {w_rem_next, w_quo_next};
                    r_done  <= 1'b1;
                    r_stall <= 1'b0;
                end
            end else if (w_accept) begin
                r_c    <= w_single;
                r_done <= 1'b1;
            end
        end
    end

    assign Stall = r_stall;
`else
    assign w_accept = Valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_c    <= w_single;
                r_done <= 1'b1;
            end
        end
    end

    assign Stall = 1'b0;
`endif

    assign C    = r_c;
    assign Done = r_done;

endmodule

// File: tb/tb_calci_core.sv
// Self-checking bench for calci_core: directed scenarios plus a randomized run against a
// cycle-level reference model; follows CALCI_DIV_EN the same way the design does.
module tb_calci_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        Valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [1:0]  ctrl;
    logic        Stall;
    logic [15:0] C;
    logic        Done;

    int checks   = 0;
    int failures = 0;

    calci_core #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .Valid (Valid),
        .A     (A),
        .B     (B),
        .ctrl  (ctrl),
        .Stall (Stall),
        .C     (C),
        .Done  (Done)
    );

    always #5 clk = ~clk;

    // Expected result of one operation, from plain integer arithmetic.
    function automatic logic [15:0] refResult(input int a, input int b, input int op);
        case (op)
            0: return 16'(a + b);
            1: return 16'(a - b);
            2: return 16'(a * b);
            default: begin
                if (b == 0) begin
`ifdef CALCI_DIV_EN
                    return 16'((a << 8) | 255);
`else
                    return 16'h0000;
`endif
                end
`ifdef CALCI_DIV_EN
                return 16'(((a % b) << 8) | (a / b));
`else
                return 16'h0000;
`endif
            end
        endcase
    endfunction

    // Advance one rising edge and land 1ns after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        Valid = v;
        A     = a;
        B     = b;
        ctrl  = op;
    endtask

    task automatic doReset();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        rst = 1'b1;
        #3;
        checks++; if (C !== 16'h0000) begin failures++; $display("[TB] FAIL reset_C got=%h exp=0000", C); end
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL reset_Done got=%b exp=0", Done); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_Stall got=%b exp=0", Stall); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        present(1'b1, 8'd200, 8'd100, 2'b00);
        tick();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        checks++; if (C !== 16'h012C) begin failures++; $display("[TB] FAIL add_C got=%h exp=012C", C); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL add_Done got=%b exp=1", Done); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL add_Stall got=%b exp=0", Stall); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL add_Done_fall got=%b exp=0", Done); end
        checks++; if (C !== 16'h012C) begin failures++; $display("[TB] FAIL add_C_hold got=%h exp=012C", C); end
    endtask

    task automatic test_back_to_back();
        present(1'b1, 8'd3, 8'd5, 2'b01);
        tick();
        checks++; if (C !== 16'hFFFE) begin failures++; $display("[TB] FAIL sub_C got=%h exp=FFFE", C); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL sub_Done got=%b exp=1", Done); end
        present(1'b1, 8'd255, 8'd255, 2'b10);
        tick();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        checks++; if (C !== 16'hFE01) begin failures++; $display("[TB] FAIL mul_C got=%h exp=FE01", C); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL mul_Done got=%b exp=1", Done); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_Done_fall got=%b exp=0", Done); end
    endtask

    task automatic test_div();
`ifdef CALCI_DIV_EN
        int stallCycles = 0;
        present(1'b1, 8'd200, 8'd7, 2'b11);
        tick();
        // Hold a new add on the bus through the stall; it must wait for Stall to fall.
        present(1'b1, 8'd10, 8'd20, 2'b00);
        for (int i = 1; i <= 8; i++) begin
            if (Stall === 1'b1) stallCycles++;
            checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL div_Done_early cyc=%0d got=%b exp=0", i, Done); end
            tick();
        end
        checks++; if (stallCycles != 8) begin failures++; $display("[TB] FAIL div_stall_len got=%0d exp=8", stallCycles); end
        checks++; if (C !== 16'h041C) begin failures++; $display("[TB] FAIL div_C got=%h exp=041C", C); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL div_Done got=%b exp=1", Done); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL div_Stall_fall got=%b exp=0", Stall); end
        tick();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        checks++; if (C !== 16'h001E) begin failures++; $display("[TB] FAIL div_held_op_C got=%h exp=001E", C); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL div_held_op_Done got=%b exp=1", Done); end
        tick();
`else
        present(1'b1, 8'd9, 8'd3, 2'b11);
        tick();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        checks++; if (C !== 16'h0000) begin failures++; $display("[TB] FAIL divoff_C got=%h exp=0000", C); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL divoff_Done got=%b exp=1", Done); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL divoff_Stall got=%b exp=0", Stall); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL divoff_Done_fall got=%b exp=0", Done); end
`endif
    endtask

    task automatic test_div_zero();
        logic [15:0] exp = refResult(17, 0, 3);
        present(1'b1, 8'd17, 8'd0, 2'b11);
        tick();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        checks++; if (C !== exp) begin failures++; $display("[TB] FAIL div0_C got=%h exp=%h", C, exp); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL div0_Done got=%b exp=1", Done); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL div0_Stall got=%b exp=0", Stall); end
        tick();
        checks++; if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL div0_Stall_after got=%b exp=0", Stall); end
    endtask

    task automatic test_reset_mid_div();
        int sawDone = 0;
        present(1'b1, 8'd200, 8'd7, 2'b11);
        tick();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #2;
        checks++; if (C !== 16'h0000) begin failures++; $display("[TB] FAIL middiv_rst_C got=%h exp=0000", C); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("[TB] FAIL middiv_rst_Stall got=%b exp=0", Stall); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Done === 1'b1) sawDone++;
        end
        checks++; if (sawDone != 0) begin failures++; $display("[TB] FAIL middiv_no_Done got=%0d exp=0", sawDone); end
        present(1'b1, 8'd1, 8'd1, 2'b00);
        tick();
        present(1'b0, 8'h00, 8'h00, 2'b00);
        checks++; if (C !== 16'h0002) begin failures++; $display("[TB] FAIL middiv_add_C got=%h exp=0002", C); end
        checks++; if (Done !== 1'b1) begin failures++; $display("[TB] FAIL middiv_add_Done got=%b exp=1", Done); end
        tick();
    endtask

    // Random traffic: the model only tracks a busy countdown and the pending divide result.
    task automatic test_random();
        logic [15:0] expC = 16'h0000;
        logic [15:0] pending = 16'h0000;
        logic        expDone;
        int          busy = 0;
        logic        v;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            v  = ($urandom_range(0, 3) != 0);
            a  = 8'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            op = 2'($urandom_range(0, 3));
            present(v, a, b, op);
            tick();
            expDone = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    expC    = pending;
                    expDone = 1'b1;
                end
            end else if (v) begin
`ifdef CALCI_DIV_EN
                if (op == 2'b11 && b != 0) begin
                    busy    = 8;
                    pending = refResult(a, b, op);
                end else begin
                    expC    = refResult(a, b, op);
                    expDone = 1'b1;
                end
`else
                expC    = refResult(a, b, op);
                expDone = 1'b1;
`endif
            end
            checks++; if (C !== expC) begin failures++; $display("[TB] FAIL rand_C cyc=%0d got=%h exp=%h", cyc, C, expC); end
            checks++; if (Done !== expDone) begin failures++; $display("[TB] FAIL rand_Done cyc=%0d got=%b exp=%b", cyc, Done, expDone); end
            checks++; if (Stall !== (busy > 0)) begin failures++; $display("[TB] FAIL rand_Stall cyc=%0d got=%b exp=%b", cyc, Stall, (busy > 0)); end
        end
        present(1'b0, 8'h00, 8'h00, 2'b00);
    endtask

    initial begin
        rst = 1'b0;
        present(1'b0, 8'h00, 8'h00, 2'b00);
        #2;
        test_reset();
        test_add();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_reset_mid_div();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
